// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: R-type func codes,
// FSM state and operation-kind encodings, and small func-decode helpers.
package muldiv_pkg;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  typedef enum logic {
    MUL,
    DIV
  } op_t;

  // True for the four multi-cycle arithmetic ops.
  function automatic logic is_calc_op(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

  function automatic logic is_div_op(input logic [5:0] f);
    return (f == FN_DIV) || (f == FN_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration of the shared datapath: a shift-add multiply
// step or a restoring-divide step over the {upper, lower} working pair.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] upper,
  input  logic [WIDTH-1:0] lower,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] upper_next,
  output logic [WIDTH-1:0] lower_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    upper_next = upper;
    lower_next = lower;
    sum        = '0;
    rem_sh     = '0;
    diff       = '0;
    if (op == MUL) begin
      // Multiplier sits in the lower half; its LSB gates the add, and the
      // carry shifts into the top of the accumulator.
      sum = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
      {upper_next, lower_next} = {sum, lower[WIDTH-1:1]};
    end else begin
      rem_sh = {upper, lower[WIDTH-1]};
      // When the trial subtract succeeds the true difference is below the
      // divisor, so the low WIDTH bits are exact.
      diff   = rem_sh[WIDTH-1:0] - operand;
      if (rem_sh >= {1'b0, operand}) begin
        upper_next = diff;
        lower_next = {lower[WIDTH-2:0], 1'b1};
      end else begin
        upper_next = rem_sh[WIDTH-1:0];
        lower_next = {lower[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle MULT/DIV sequencer owning architectural HI/LO; computes on
// operand magnitudes for WIDTH iterations, then applies the sign fix-up.
module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mf_req,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  op_t              op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] acc, low, divisor;
  logic [WIDTH-1:0] acc_step, low_step;
  logic             start, mt_hi, mt_lo;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [2*WIDTH-1:0] product;

  assign rs_neg = is_signed_op(func) & rs_val[WIDTH-1];
  assign rt_neg = is_signed_op(func) & rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;

  assign busy  = (state != IDLE);
  assign stall = busy & (issue | mf_req);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    mt_hi      = 1'b0;
    mt_lo      = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            if (is_calc_op(func)) begin
              start      = 1'b1;
              state_next = CALC;
            end
            mt_hi = (func == FN_MTHI);
            mt_lo = (func == FN_MTLO);
          end
        end
        CALC:    if (cnt == CW'(WIDTH - 1)) state_next = FIX;
        FIX:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .op         (op),
    .upper      (acc),
    .lower      (low),
    .operand    (divisor),
    .upper_next (acc_step),
    .lower_next (low_step)
  );

  // Both ops start from acc=0 with the |rs| in the lower half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op      <= MUL;
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
      acc     <= '0;
      low     <= '0;
      divisor <= '0;
    end else if (start) begin
      cnt     <= '0;
      op      <= is_div_op(func) ? DIV : MUL;
      a_neg   <= rs_neg;
      b_neg   <= rt_neg;
      acc     <= '0;
      low     <= rs_mag;
      divisor <= rt_mag;
    end else if (state == CALC && !flush) begin
      cnt <= cnt + 1'b1;
      acc <= acc_step;
      low <= low_step;
    end
  end

  assign product = {acc, low};

  always_comb begin
    fix_hi = '0;
    fix_lo = '0;
    if (op == MUL) begin
      {fix_hi, fix_lo} = (a_neg ^ b_neg) ? -product : product;
    end else begin
      // With a zero divisor every trial subtract succeeds, so acc ends holding
      // |rs|; re-applying the dividend sign returns rs_val unchanged.
      fix_hi = a_neg ? -acc : acc;
      if (divisor == '0) fix_lo = '1;
      else               fix_lo = (a_neg ^ b_neg) ? -low : low;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX && !flush) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else begin
      if (mt_hi) hi <= rs_val;
      if (mt_lo) lo <= rs_val;
    end
  end

endmodule
